// File: rtl/relu_pool2.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster-ordered stream.
// One row of partial maxima is kept; odd trailing rows/columns are dropped.
module relu_pool2 #(
  parameter int W3  = 21,
  parameter int IMG = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [W3-1:0] inp,
  input  logic                 En_in,
  output logic signed [W3-1:0] oup,
  output logic                 En,
  output logic                 done
);

  localparam int P  = IMG / 2;
  localparam int CW = (IMG > 1) ? $clog2(IMG) : 1;
  localparam int LW = (P > 1) ? $clog2(P) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMG - 1);

  function automatic logic signed [W3-1:0] relu(input logic signed [W3-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction

  function automatic logic signed [W3-1:0] max2(input logic signed [W3-1:0] a,
                                                input logic signed [W3-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0]        col_q, col_d;
  logic [CW-1:0]        row_q, row_d;
  logic signed [W3-1:0] hold_q, hold_d;
  logic signed [W3-1:0] lb_q [P];
  logic signed [W3-1:0] lb_d [P];
  logic signed [W3-1:0] oup_q, oup_d;
  logic                 en_q, en_d;
  logic                 done_q, done_d;

  logic signed [W3-1:0] r;
  logic [LW-1:0]        idx;
  logic                 in_win;
  logic                 last_win;

  assign r        = relu(inp);
  assign idx      = LW'(col_q >> 1);
  assign in_win   = (int'(col_q) < 2 * P) && (int'(row_q) < 2 * P);
  assign last_win = (int'(col_q) == 2 * P - 1) && (int'(row_q) == 2 * P - 1);

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    hold_d = hold_q;
    lb_d   = lb_q;
    oup_d  = oup_q;
    en_d   = 1'b0;
    done_d = 1'b0;
    if (En_in) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      // Even column opens a window pair; even row stores the top-row max;
      // odd row completes the 2x2 window.
      if (in_win) begin
        if (!col_q[0]) begin
          hold_d = r;
        end else if (!row_q[0]) begin
          lb_d[idx] = max2(hold_q, r);
        end else begin
          oup_d  = max2(lb_q[idx], max2(hold_q, r));
          en_d   = 1'b1;
          done_d = last_win;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q  <= '0;
      row_q  <= '0;
      hold_q <= '0;
      for (int i = 0; i < P; i++) lb_q[i] <= '0;
      oup_q  <= '0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      hold_q <= hold_d;
      lb_q   <= lb_d;
      oup_q  <= oup_d;
      en_q   <= en_d;
      done_q <= done_d;
    end
  end

  assign oup  = oup_q;
  assign En   = en_q;
  assign done = done_q;

endmodule

// File: tb/tb_relu_pool2.sv
// Directed bench for relu_pool2 (IMG=7): ramp, negative, spike, bubbles,
// back-to-back frames and asynchronous reset mid-frame.
module tb_relu_pool2;

  localparam int W3  = 21;
  localparam int IMG = 7;

  logic                 clk;
  logic                 rst;
  logic signed [W3-1:0] inp;
  logic                 En_in;
  logic signed [W3-1:0] oup;
  logic                 En;
  logic                 done;

  relu_pool2 #(.W3(W3), .IMG(IMG)) dut (
    .clk  (clk),
    .rst  (rst),
    .inp  (inp),
    .En_in(En_in),
    .oup  (oup),
    .En   (En),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int lat_err = 0;

  logic drv_win;
  logic win_s;
  int   got_v[$];
  bit   got_d[$];
  int   exp_v[$];
  bit   exp_d[$];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bench's own view of which accepted beat completes a window.
  always @(posedge clk or negedge rst) begin
    if (!rst) win_s <= 1'b0;
    else      win_s <= En_in & drv_win;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (En !== win_s) lat_err++;
      if (done && !En) lat_err++;
      if (En) begin
        got_v.push_back(int'(oup));
        got_d.push_back(done);
      end
    end
  end

  function automatic logic signed [W3-1:0] pix(input int mode, input int r, input int c);
    case (mode)
      0:       return W3'(r * 7 + c);
      1:       return -21'sd5;
      2:       return (r == 6 && c == 6) ? 21'sd1000 : 21'sd0;
      3:       return (r == 2 && c == 3) ? 21'sd1000 : 21'sd0;
      default: return W3'(-(r * 7 + c));
    endcase
  endfunction

  task automatic beat(input logic signed [W3-1:0] v, input bit win);
    @(posedge clk); #1;
    inp = v; En_in = 1'b1; drv_win = win;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      En_in = 1'b0; drv_win = 1'b0;
    end
  endtask

  task automatic frame(input int mode, input bit bub, input int nbeats);
    int k;
    k = 0;
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < IMG; c++) begin
        if (k < nbeats) begin
          if (bub) idle($urandom_range(0, 2));
          beat(pix(mode, r, c), (r % 2 == 1) && (c % 2 == 1) && r < 6 && c < 6);
        end
        k++;
      end
  endtask

  task automatic exp_push(input int mode);
    int ramp [9] = '{8, 10, 12, 22, 24, 26, 36, 38, 40};
    for (int i = 0; i < 9; i++) begin
      case (mode)
        0:       exp_v.push_back(ramp[i]);
        3:       exp_v.push_back(i == 4 ? 1000 : 0);
        default: exp_v.push_back(0);
      endcase
      exp_d.push_back(i == 8);
    end
  endtask

  task automatic check_frame(input string tag);
    check_eq({tag, "_count"}, got_v.size(), exp_v.size());
    for (int i = 0; i < exp_v.size(); i++) begin
      if (i < got_v.size()) begin
        check_eq($sformatf("%s_oup%0d", tag, i), got_v[i], exp_v[i]);
        check_eq($sformatf("%s_done%0d", tag, i), got_d[i], exp_d[i]);
      end
    end
    check_eq({tag, "_timing"}, lat_err, 0);
    lat_err = 0;
    got_v.delete(); got_d.delete(); exp_v.delete(); exp_d.delete();
  endtask

  initial begin
    rst = 1'b0; inp = '0; En_in = 1'b0; drv_win = 1'b0;
    #12;
    check_eq("rst_oup", oup, 0);
    check_eq("rst_en", En, 0);
    check_eq("rst_done", done, 0);
    @(posedge clk); #1 rst = 1'b1;

    frame(0, 1'b0, 49); idle(3); exp_push(0); check_frame("ramp");
    frame(1, 1'b0, 49); idle(3); exp_push(1); check_frame("neg5");
    frame(2, 1'b0, 49); idle(3); exp_push(2); check_frame("spike66");
    frame(3, 1'b0, 49); idle(3); exp_push(3); check_frame("spike23");
    frame(0, 1'b1, 49); idle(3); exp_push(0); check_frame("bubbles");

    frame(0, 1'b0, 49); frame(4, 1'b0, 49); idle(3);
    exp_push(0); exp_push(4); check_frame("b2b");

    // Partial frame, then asynchronous reset between clock edges.
    frame(0, 1'b0, 20);
    @(posedge clk); #1;
    En_in = 1'b0; drv_win = 1'b0;
    check_eq("pre_rst_oup", oup, 12);
    #2 rst = 1'b0;
    #1;
    check_eq("async_oup", oup, 0);
    check_eq("async_en", En, 0);
    check_eq("async_done", done, 0);
    got_v.delete(); got_d.delete(); lat_err = 0;
    repeat (2) begin
      @(negedge clk);
      check_eq("inrst_en", En, 0);
      check_eq("inrst_oup", oup, 0);
    end
    @(posedge clk); #1 rst = 1'b1;
    frame(0, 1'b0, 49); idle(3); exp_push(0); check_frame("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
